// File: rtl/mwrite.sv
// mwrite: memory-write pipeline stage.
// Merges load/ALU writeback, issues stores to the MMU, times out stalled stores.
module mwrite #(
    parameter int WTIMEOUT = 255
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        FLUSH,
    input  logic        STALL,
    input  logic        MEMR_MEM_R_VALID,
    input  logic [4:0]  MEMR_MEM_R_RD,
    input  logic [31:0] MEMR_MEM_R_DATA,
    input  logic [4:0]  MEMR_REG_W_RD,
    input  logic [31:0] MEMR_REG_W_DATA,
    input  logic [11:0] MEMR_CSR_W_ADDR,
    input  logic [31:0] MEMR_CSR_W_DATA,
    input  logic        MEMR_MEM_W_VALID,
    input  logic [31:0] MEMR_MEM_W_ADDR,
    input  logic [3:0]  MEMR_MEM_W_STRB,
    input  logic [31:0] MEMR_MEM_W_DATA,
    input  logic        MEMR_JMP_DO,
    input  logic [31:0] MEMR_JMP_PC,
    output logic        DATA_WREN,
    output logic [31:0] DATA_WADDR,
    output logic [3:0]  DATA_WSTRB,
    output logic [31:0] DATA_WDATA,
    input  logic        DATA_WREADY,
    output logic        MEMW_STALL_REQ,
    output logic [4:0]  MEMW_REG_W_RD,
    output logic [31:0] MEMW_REG_W_DATA,
    output logic [11:0] MEMW_CSR_W_ADDR,
    output logic [31:0] MEMW_CSR_W_DATA,
    output logic        MEMW_JMP_DO,
    output logic [31:0] MEMW_JMP_PC,
    output logic        MEMW_ERR
);

    localparam logic S_IDLE = 1'b0;
    localparam logic S_WAIT = 1'b1;

    logic        state;
    logic [7:0]  cnt;
    logic        err;
    logic [4:0]  rd;
    logic [31:0] rdata;
    logic [11:0] csr_addr;
    logic [31:0] csr_data;
    logic        jmp_do;
    logic [31:0] jmp_pc;
    logic [31:0] waddr;
    logic [3:0]  wstrb;
    logic [31:0] wdata;

    logic done;
    logic tmo;
    logic capture;
    logic commit_ok;

    assign done      = (state == S_WAIT) && DATA_WREADY;
    assign tmo       = (state == S_WAIT) && !DATA_WREADY
                       && (cnt == 8'(WTIMEOUT - 1));
    assign capture   = !STALL && !FLUSH && ((state == S_IDLE) || done);
    assign commit_ok = (state == S_IDLE) || DATA_WREADY;

    // Store FSM: wait for the MMU handshake or give up after WTIMEOUT cycles
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state <= S_IDLE;
            cnt   <= '0;
            err   <= 1'b0;
        end else begin
            err <= tmo;
            if (capture && MEMR_MEM_W_VALID) begin
                state <= S_WAIT;
                cnt   <= '0;
            end else if (done || tmo) begin
                state <= S_IDLE;
                cnt   <= '0;
            end else if (state == S_WAIT) begin
                cnt <= cnt + 8'd1;
            end
        end
    end

    // Store fields: flush never touches them so an issued store always finishes
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            waddr <= '0;
            wstrb <= '0;
            wdata <= '0;
        end else if (capture) begin
            waddr <= MEMR_MEM_W_ADDR;
            wstrb <= MEMR_MEM_W_STRB;
            wdata <= MEMR_MEM_W_DATA;
        end
    end

    // Commit fields: load wins over ALU; flush or abandoned store kills them
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            rd       <= '0;
            rdata    <= '0;
            csr_addr <= '0;
            csr_data <= '0;
            jmp_do   <= 1'b0;
            jmp_pc   <= '0;
        end else if (FLUSH || tmo) begin
            rd       <= '0;
            rdata    <= '0;
            csr_addr <= '0;
            csr_data <= '0;
            jmp_do   <= 1'b0;
            jmp_pc   <= '0;
        end else if (capture) begin
            rd       <= MEMR_MEM_R_VALID ? MEMR_MEM_R_RD : MEMR_REG_W_RD;
            rdata    <= MEMR_MEM_R_VALID ? MEMR_MEM_R_DATA : MEMR_REG_W_DATA;
            csr_addr <= MEMR_CSR_W_ADDR;
            csr_data <= MEMR_CSR_W_DATA;
            jmp_do   <= MEMR_JMP_DO;
            jmp_pc   <= MEMR_JMP_PC;
        end
    end

    assign DATA_WREN       = (state == S_WAIT);
    assign DATA_WADDR      = waddr;
    assign DATA_WSTRB      = wstrb;
    assign DATA_WDATA      = wdata;
    assign MEMW_STALL_REQ  = (state == S_WAIT) && !DATA_WREADY;
    assign MEMW_REG_W_RD   = commit_ok ? rd : 5'd0;
    assign MEMW_REG_W_DATA = rdata;
    assign MEMW_CSR_W_ADDR = commit_ok ? csr_addr : 12'd0;
    assign MEMW_CSR_W_DATA = csr_data;
    assign MEMW_JMP_DO     = commit_ok && jmp_do;
    assign MEMW_JMP_PC     = jmp_pc;
    assign MEMW_ERR        = err;

endmodule

// File: tb/tb_mwrite.sv
// tb_mwrite: directed self-checking bench for mwrite.
// Uses WTIMEOUT=4 so the timeout path is reached quickly.
module tb_mwrite;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        FLUSH = 1'b0;
    logic        STALL = 1'b0;
    logic        MEMR_MEM_R_VALID = 1'b0;
    logic [4:0]  MEMR_MEM_R_RD = '0;
    logic [31:0] MEMR_MEM_R_DATA = '0;
    logic [4:0]  MEMR_REG_W_RD = '0;
    logic [31:0] MEMR_REG_W_DATA = '0;
    logic [11:0] MEMR_CSR_W_ADDR = '0;
    logic [31:0] MEMR_CSR_W_DATA = '0;
    logic        MEMR_MEM_W_VALID = 1'b0;
    logic [31:0] MEMR_MEM_W_ADDR = '0;
    logic [3:0]  MEMR_MEM_W_STRB = '0;
    logic [31:0] MEMR_MEM_W_DATA = '0;
    logic        MEMR_JMP_DO = 1'b0;
    logic [31:0] MEMR_JMP_PC = '0;
    logic        DATA_WREN;
    logic [31:0] DATA_WADDR;
    logic [3:0]  DATA_WSTRB;
    logic [31:0] DATA_WDATA;
    logic        DATA_WREADY = 1'b0;
    logic        MEMW_STALL_REQ;
    logic [4:0]  MEMW_REG_W_RD;
    logic [31:0] MEMW_REG_W_DATA;
    logic [11:0] MEMW_CSR_W_ADDR;
    logic [31:0] MEMW_CSR_W_DATA;
    logic        MEMW_JMP_DO;
    logic [31:0] MEMW_JMP_PC;
    logic        MEMW_ERR;

    int checks = 0;
    int failures = 0;

    mwrite #(.WTIMEOUT(4)) dut (
        .CLK(CLK), .RST(RST), .FLUSH(FLUSH), .STALL(STALL),
        .MEMR_MEM_R_VALID(MEMR_MEM_R_VALID),
        .MEMR_MEM_R_RD(MEMR_MEM_R_RD),
        .MEMR_MEM_R_DATA(MEMR_MEM_R_DATA),
        .MEMR_REG_W_RD(MEMR_REG_W_RD),
        .MEMR_REG_W_DATA(MEMR_REG_W_DATA),
        .MEMR_CSR_W_ADDR(MEMR_CSR_W_ADDR),
        .MEMR_CSR_W_DATA(MEMR_CSR_W_DATA),
        .MEMR_MEM_W_VALID(MEMR_MEM_W_VALID),
        .MEMR_MEM_W_ADDR(MEMR_MEM_W_ADDR),
        .MEMR_MEM_W_STRB(MEMR_MEM_W_STRB),
        .MEMR_MEM_W_DATA(MEMR_MEM_W_DATA),
        .MEMR_JMP_DO(MEMR_JMP_DO),
        .MEMR_JMP_PC(MEMR_JMP_PC),
        .DATA_WREN(DATA_WREN), .DATA_WADDR(DATA_WADDR),
        .DATA_WSTRB(DATA_WSTRB), .DATA_WDATA(DATA_WDATA),
        .DATA_WREADY(DATA_WREADY),
        .MEMW_STALL_REQ(MEMW_STALL_REQ),
        .MEMW_REG_W_RD(MEMW_REG_W_RD),
        .MEMW_REG_W_DATA(MEMW_REG_W_DATA),
        .MEMW_CSR_W_ADDR(MEMW_CSR_W_ADDR),
        .MEMW_CSR_W_DATA(MEMW_CSR_W_DATA),
        .MEMW_JMP_DO(MEMW_JMP_DO),
        .MEMW_JMP_PC(MEMW_JMP_PC),
        .MEMW_ERR(MEMW_ERR)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic clr_in();
        MEMR_MEM_R_VALID = 1'b0;
        MEMR_MEM_R_RD    = '0;
        MEMR_MEM_R_DATA  = '0;
        MEMR_REG_W_RD    = '0;
        MEMR_REG_W_DATA  = '0;
        MEMR_CSR_W_ADDR  = '0;
        MEMR_CSR_W_DATA  = '0;
        MEMR_MEM_W_VALID = 1'b0;
        MEMR_MEM_W_ADDR  = '0;
        MEMR_MEM_W_STRB  = '0;
        MEMR_MEM_W_DATA  = '0;
        MEMR_JMP_DO      = 1'b0;
        MEMR_JMP_PC      = '0;
    endtask

    initial begin
        // reset state
        #3;
        chk("rst_wren", 32'(DATA_WREN), 32'd0);
        chk("rst_stall", 32'(MEMW_STALL_REQ), 32'd0);
        chk("rst_rd", 32'(MEMW_REG_W_RD), 32'd0);
        chk("rst_err", 32'(MEMW_ERR), 32'd0);
        tick();
        RST = 1'b1;
        tick();

        // ALU writeback with CSR
        MEMR_REG_W_RD   = 5'd5;
        MEMR_REG_W_DATA = 32'h1234;
        MEMR_CSR_W_ADDR = 12'h305;
        MEMR_CSR_W_DATA = 32'hCAFE;
        tick();
        clr_in();
        chk("alu_rd", 32'(MEMW_REG_W_RD), 32'd5);
        chk("alu_data", MEMW_REG_W_DATA, 32'h1234);
        chk("alu_csr_a", 32'(MEMW_CSR_W_ADDR), 32'h305);
        chk("alu_csr_d", MEMW_CSR_W_DATA, 32'hCAFE);
        chk("alu_wren", 32'(DATA_WREN), 32'd0);
        chk("alu_stall", 32'(MEMW_STALL_REQ), 32'd0);

        // load beats ALU
        MEMR_MEM_R_VALID = 1'b1;
        MEMR_MEM_R_RD    = 5'd7;
        MEMR_MEM_R_DATA  = 32'hFFFF_FF80;
        MEMR_REG_W_RD    = 5'd3;
        MEMR_REG_W_DATA  = 32'h55;
        tick();
        clr_in();
        chk("ld_rd", 32'(MEMW_REG_W_RD), 32'd7);
        chk("ld_data", MEMW_REG_W_DATA, 32'hFFFF_FF80);

        // store, ready on 4th wait cycle
        MEMR_MEM_W_VALID = 1'b1;
        MEMR_MEM_W_ADDR  = 32'h100;
        MEMR_MEM_W_STRB  = 4'b0011;
        MEMR_MEM_W_DATA  = 32'hBEEF;
        MEMR_REG_W_RD    = 5'd4;
        MEMR_REG_W_DATA  = 32'h77;
        MEMR_JMP_DO      = 1'b1;
        MEMR_JMP_PC      = 32'h200;
        tick();
        clr_in();
        for (int i = 0; i < 3; i++) begin
            chk("st_wren", 32'(DATA_WREN), 32'd1);
            chk("st_addr", DATA_WADDR, 32'h100);
            chk("st_strb", 32'(DATA_WSTRB), 32'h3);
            chk("st_wdata", DATA_WDATA, 32'hBEEF);
            chk("st_stall", 32'(MEMW_STALL_REQ), 32'd1);
            chk("st_rd_gate", 32'(MEMW_REG_W_RD), 32'd0);
            chk("st_jmp_gate", 32'(MEMW_JMP_DO), 32'd0);
            tick();
        end
        DATA_WREADY = 1'b1;
        #1;
        chk("st_rdy_wren", 32'(DATA_WREN), 32'd1);
        chk("st_rdy_stall", 32'(MEMW_STALL_REQ), 32'd0);
        chk("st_rdy_rd", 32'(MEMW_REG_W_RD), 32'd4);
        chk("st_rdy_data", MEMW_REG_W_DATA, 32'h77);
        chk("st_rdy_jmp", 32'(MEMW_JMP_DO), 32'd1);
        chk("st_rdy_pc", MEMW_JMP_PC, 32'h200);
        tick();
        DATA_WREADY = 1'b0;
        chk("st_done_wren", 32'(DATA_WREN), 32'd0);
        chk("st_done_stall", 32'(MEMW_STALL_REQ), 32'd0);
        chk("st_done_rd", 32'(MEMW_REG_W_RD), 32'd0);

        // store timeout
        MEMR_MEM_W_VALID = 1'b1;
        MEMR_MEM_W_ADDR  = 32'h104;
        MEMR_REG_W_RD    = 5'd6;
        MEMR_REG_W_DATA  = 32'h66;
        MEMR_JMP_DO      = 1'b1;
        MEMR_JMP_PC      = 32'h400;
        tick();
        clr_in();
        for (int i = 0; i < 4; i++) begin
            chk("to_wren", 32'(DATA_WREN), 32'd1);
            chk("to_err_early", 32'(MEMW_ERR), 32'd0);
            tick();
        end
        chk("to_err", 32'(MEMW_ERR), 32'd1);
        chk("to_wren_drop", 32'(DATA_WREN), 32'd0);
        chk("to_rd", 32'(MEMW_REG_W_RD), 32'd0);
        chk("to_jmp", 32'(MEMW_JMP_DO), 32'd0);
        chk("to_stall", 32'(MEMW_STALL_REQ), 32'd0);
        tick();
        chk("to_err_pulse", 32'(MEMW_ERR), 32'd0);
        chk("to_rd_after", 32'(MEMW_REG_W_RD), 32'd0);

        // flush during wait
        MEMR_MEM_W_VALID = 1'b1;
        MEMR_MEM_W_ADDR  = 32'h108;
        MEMR_REG_W_RD    = 5'd9;
        MEMR_JMP_DO      = 1'b1;
        MEMR_JMP_PC      = 32'h300;
        tick();
        clr_in();
        chk("fl_wren0", 32'(DATA_WREN), 32'd1);
        FLUSH = 1'b1;
        tick();
        FLUSH = 1'b0;
        chk("fl_wren1", 32'(DATA_WREN), 32'd1);
        chk("fl_addr", DATA_WADDR, 32'h108);
        DATA_WREADY = 1'b1;
        #1;
        chk("fl_rd", 32'(MEMW_REG_W_RD), 32'd0);
        chk("fl_jmp", 32'(MEMW_JMP_DO), 32'd0);
        chk("fl_wren2", 32'(DATA_WREN), 32'd1);
        tick();
        DATA_WREADY = 1'b0;
        chk("fl_wren3", 32'(DATA_WREN), 32'd0);

        // stall holds, flush under stall clears
        MEMR_REG_W_RD   = 5'd11;
        MEMR_REG_W_DATA = 32'hAB;
        tick();
        chk("sh_rd0", 32'(MEMW_REG_W_RD), 32'd11);
        STALL = 1'b1;
        MEMR_REG_W_RD   = 5'd12;
        MEMR_REG_W_DATA = 32'hCD;
        tick();
        chk("sh_rd1", 32'(MEMW_REG_W_RD), 32'd11);
        chk("sh_data1", MEMW_REG_W_DATA, 32'hAB);
        FLUSH = 1'b1;
        tick();
        chk("sfl_rd", 32'(MEMW_REG_W_RD), 32'd0);
        FLUSH = 1'b0;
        STALL = 1'b0;
        clr_in();

        // async reset mid-wait
        MEMR_MEM_W_VALID = 1'b1;
        MEMR_MEM_W_ADDR  = 32'h10C;
        MEMR_REG_W_RD    = 5'd2;
        tick();
        clr_in();
        chk("ar_wren0", 32'(DATA_WREN), 32'd1);
        #2;
        RST = 1'b0;
        #1;
        chk("ar_wren", 32'(DATA_WREN), 32'd0);
        chk("ar_stall", 32'(MEMW_STALL_REQ), 32'd0);
        chk("ar_addr", DATA_WADDR, 32'd0);
        chk("ar_rd", 32'(MEMW_REG_W_RD), 32'd0);
        #1;
        RST = 1'b1;
        tick();
        chk("ar_idle", 32'(DATA_WREN), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
